// File: rtl/arf_stream_sequencer.sv
// ---------------------------------------------------------------------------
// arf_stream_sequencer
//   Upstream feeder and result collector for the ARF variance datapath.
//   Collects NUM_IN operand words from a valid/ready stream into a frame
//   register and holds that frame on arf_in while the datapath settles for
//   SETTLE cycles. It then captures out_27/out_28 and offers the pair on a
//   valid/ready result port. Frames never overlap: a new frame is only
//   accepted once the previous result has been taken.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   s_valid/s_ready/s_data operand stream (one word per handshake)
//   arf_in                 frame operands, slot k at [k*WIDTH +: WIDTH]
//   arf_out_27/arf_out_28  datapath results
//   m_valid/m_ready        result handshake
//   m_data_27/m_data_28    captured result pair
//   busy                   high while settling or presenting a result
//   frame_count            completed frames, modulo 256
// ---------------------------------------------------------------------------
module arf_stream_sequencer #(
   parameter int WIDTH  = 16,
   parameter int RWIDTH = 32,
   parameter int NUM_IN = 10,
   parameter int SETTLE = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic [WIDTH-1:0]          s_data,
   output logic [WIDTH*NUM_IN-1:0]   arf_in,
   input  logic [RWIDTH-1:0]         arf_out_27,
   input  logic [RWIDTH-1:0]         arf_out_28,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [RWIDTH-1:0]         m_data_27,
   output logic [RWIDTH-1:0]         m_data_28,
   output logic                      busy,
   output logic [7:0]                frame_count
);

   localparam int IDXW = $clog2(NUM_IN);

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_OUT    = 2'd2
   } state_e;

   state_e            state_q;
   logic [IDXW-1:0]   idx_q;
   logic [7:0]        cnt_q;
   logic [WIDTH-1:0]  slot_q [NUM_IN];
   logic              s_ready_q;
   logic              busy_q;
   logic              m_valid_q;
   logic [RWIDTH-1:0] m_data_27_q;
   logic [RWIDTH-1:0] m_data_28_q;
   logic [7:0]        frame_count_q;

   // Sequencer FSM: frame loading, settle countdown and result hand-off.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_LOAD;
         idx_q         <= '0;
         cnt_q         <= 8'd0;
         s_ready_q     <= 1'b1;
         busy_q        <= 1'b0;
         m_valid_q     <= 1'b0;
         m_data_27_q   <= '0;
         m_data_28_q   <= '0;
         frame_count_q <= 8'd0;
         for (int k = 0; k < NUM_IN; k++) begin
            slot_q[k] <= '0;
         end
      end else begin
         case (state_q)
            ST_LOAD: begin
               if (s_valid && s_ready_q) begin
                  slot_q[idx_q] <= s_data;
                  if (idx_q == IDXW'(NUM_IN - 1)) begin
                     // Last operand: freeze the frame and start the settle
                     // countdown so capture happens SETTLE edges later.
                     idx_q     <= '0;
                     cnt_q     <= 8'(SETTLE - 1);
                     state_q   <= ST_SETTLE;
                     s_ready_q <= 1'b0;
                     busy_q    <= 1'b1;
                  end else begin
                     idx_q <= idx_q + IDXW'(1);
                  end
               end
            end
            ST_SETTLE: begin
               if (cnt_q == 8'd0) begin
                  m_data_27_q <= arf_out_27;
                  m_data_28_q <= arf_out_28;
                  m_valid_q   <= 1'b1;
                  state_q     <= ST_OUT;
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            ST_OUT: begin
               if (m_ready) begin
                  m_valid_q     <= 1'b0;
                  frame_count_q <= frame_count_q + 8'd1;
                  state_q       <= ST_LOAD;
                  s_ready_q     <= 1'b1;
                  busy_q        <= 1'b0;
               end
            end
            default: begin
               // Unreachable encoding: recover to an idle, loadable state.
               state_q   <= ST_LOAD;
               idx_q     <= '0;
               s_ready_q <= 1'b1;
               busy_q    <= 1'b0;
               m_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Flatten the frame registers onto the datapath operand bus.
   always_comb begin
      arf_in = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         arf_in[k*WIDTH +: WIDTH] = slot_q[k];
      end
   end

   assign s_ready     = s_ready_q;
   assign busy        = busy_q;
   assign m_valid     = m_valid_q;
   assign m_data_27   = m_data_27_q;
   assign m_data_28   = m_data_28_q;
   assign frame_count = frame_count_q;

endmodule

// File: tb/tb_arf_stream_sequencer.sv
// ---------------------------------------------------------------------------
// tb_arf_stream_sequencer
//   Directed bench for arf_stream_sequencer. A stub datapath returns the sum
//   (out_27) and sum of squares (out_28) of the ten operands. Expected
//   results per frame are hand-computed constants in the vector table.
// ---------------------------------------------------------------------------
module tb_arf_stream_sequencer;

   localparam int WIDTH  = 16;
   localparam int RWIDTH = 32;
   localparam int NUM_IN = 10;
   localparam int SETTLE = 4;
   localparam int FW     = WIDTH * NUM_IN;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              s_valid = 1'b0;
   logic              s_ready;
   logic [WIDTH-1:0]  s_data = '0;
   logic [FW-1:0]     arf_in;
   logic [RWIDTH-1:0] arf_out_27;
   logic [RWIDTH-1:0] arf_out_28;
   logic              m_valid;
   logic              m_ready = 1'b0;
   logic [RWIDTH-1:0] m_data_27;
   logic [RWIDTH-1:0] m_data_28;
   logic              busy;
   logic [7:0]        frame_count;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   arf_stream_sequencer #(
      .WIDTH(WIDTH), .RWIDTH(RWIDTH), .NUM_IN(NUM_IN), .SETTLE(SETTLE)
   ) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .arf_in(arf_in),
      .arf_out_27(arf_out_27), .arf_out_28(arf_out_28),
      .m_valid(m_valid), .m_ready(m_ready),
      .m_data_27(m_data_27), .m_data_28(m_data_28),
      .busy(busy), .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Stub datapath: out_27 = sum of operands, out_28 = sum of squares.
   always_comb begin
      logic [31:0] w;
      arf_out_27 = 32'd0;
      arf_out_28 = 32'd0;
      for (int k = 0; k < NUM_IN; k++) begin
         w = {16'd0, arf_in[k*WIDTH +: WIDTH]};
         arf_out_27 = arf_out_27 + w;
         arf_out_28 = arf_out_28 + w * w;
      end
   end

   typedef struct {
      logic [FW-1:0] words;
      bit            gaps;
      bit            early_ready;
      int            hold;
      logic [31:0]   e27;
      logic [31:0]   e28;
   } vec_t;

   vec_t vecs [4];

   task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [FW-1:0] seq_words(input logic [15:0] start, input logic [15:0] stp);
      logic [FW-1:0] r;
      logic [15:0]   v;
      r = '0;
      v = start;
      for (int k = 0; k < NUM_IN; k++) begin
         r[k*WIDTH +: WIDTH] = v;
         v = v + stp;
      end
      return r;
   endfunction

   // Feed the first n words of a frame; returns the cycle of the last accept.
   task automatic feed(input logic [FW-1:0] words, input int n, input bit gaps, output int last_acc);
      last_acc = 0;
      for (int k = 0; k < n; k++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               s_valid = 1'b0;
               s_data  = 16'hBAD0;
               step();
            end
         end
         chk("s_ready_in_load", FW'(s_ready), FW'(1'b1));
         s_valid = 1'b1;
         s_data  = words[k*WIDTH +: WIDTH];
         step();
         last_acc = cyc;
      end
      s_valid = 1'b0;
   endtask

   task automatic wait_mvalid(output bit seen);
      seen = 1'b0;
      for (int t = 0; t < 40; t++) begin
         if (m_valid) begin
            seen = 1'b1;
            break;
         end
         step();
      end
      if (!seen) chk("m_valid_timeout", FW'(1'b0), FW'(1'b1));
   endtask

   initial begin
      int  last_acc;
      bit  seen;
      int  pulses;
      int  bad_period;
      int  bad_width;
      int  last_pulse;
      bit  prev_mv;

      vecs[0] = '{seq_words(16'd1, 16'd1),       1'b0, 1'b0, 2,  32'h0000_0037, 32'h0000_0181};
      vecs[1] = '{seq_words(16'hFFFF, 16'd0),    1'b1, 1'b0, 20, 32'h0009_FFF6, 32'hFFEC_000A};
      vecs[2] = '{seq_words(16'd2, 16'd2),       1'b1, 1'b1, 0,  32'h0000_006E, 32'h0000_0604};
      vecs[3] = '{seq_words(16'd9, 16'hFFFF),    1'b0, 1'b0, 3,  32'h0000_002D, 32'h0000_011D};

      // Reset state
      step();
      step();
      rst = 1'b0;
      chk("rst_arf_in",      arf_in,              '0);
      chk("rst_s_ready",     FW'(s_ready),        FW'(1'b1));
      chk("rst_busy",        FW'(busy),           FW'(1'b0));
      chk("rst_m_valid",     FW'(m_valid),        FW'(1'b0));
      chk("rst_m_data_27",   FW'(m_data_27),      FW'(32'd0));
      chk("rst_m_data_28",   FW'(m_data_28),      FW'(32'd0));
      chk("rst_frame_count", FW'(frame_count),    FW'(8'd0));

      // Reset after six accepted words discards the partial frame
      feed(seq_words(16'h0700, 16'd1), 6, 1'b0, last_acc);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midload_rst_arf_in", arf_in,           '0);
      chk("midload_rst_s_ready", FW'(s_ready),    FW'(1'b1));
      chk("midload_rst_fc",     FW'(frame_count), FW'(8'd0));

      // Table-driven frames
      for (int i = 0; i < 4; i++) begin
         m_ready = vecs[i].early_ready;
         feed(vecs[i].words, NUM_IN, vecs[i].gaps, last_acc);
         chk("s_ready_drop", FW'(s_ready), FW'(1'b0));
         chk("busy_settle",  FW'(busy),    FW'(1'b1));
         wait_mvalid(seen);
         if (seen) begin
            chk("latency",   FW'(cyc - last_acc), FW'(SETTLE));
            chk("arf_in",    arf_in,          vecs[i].words);
            chk("m_data_27", FW'(m_data_27),  FW'(vecs[i].e27));
            chk("m_data_28", FW'(m_data_28),  FW'(vecs[i].e28));
         end
         for (int h = 0; h < vecs[i].hold; h++) begin
            s_valid = 1'b1;
            s_data  = 16'hDEAD;
            step();
            chk("hold_m_valid", FW'(m_valid),   FW'(1'b1));
            chk("hold_m27",     FW'(m_data_27), FW'(vecs[i].e27));
            chk("hold_m28",     FW'(m_data_28), FW'(vecs[i].e28));
            chk("hold_s_ready", FW'(s_ready),   FW'(1'b0));
            chk("hold_arf_in",  arf_in,         vecs[i].words);
         end
         s_valid = 1'b0;
         m_ready = 1'b1;
         step();
         m_ready = 1'b0;
         chk("post_hs_m_valid", FW'(m_valid),     FW'(1'b0));
         chk("post_hs_s_ready", FW'(s_ready),     FW'(1'b1));
         chk("post_hs_busy",    FW'(busy),        FW'(1'b0));
         chk("post_hs_fc",      FW'(frame_count), FW'(i + 1));
      end

      // Reset while a result is pending in OUT
      feed(vecs[0].words, NUM_IN, 1'b0, last_acc);
      wait_mvalid(seen);
      chk("out_pending_fc", FW'(frame_count), FW'(8'd4));
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("out_rst_m_valid", FW'(m_valid),     FW'(1'b0));
      chk("out_rst_fc",      FW'(frame_count), FW'(8'd0));
      chk("out_rst_s_ready", FW'(s_ready),     FW'(1'b1));
      chk("out_rst_busy",    FW'(busy),        FW'(1'b0));
      chk("out_rst_m27",     FW'(m_data_27),   FW'(32'd0));

      // 256 back-to-back frames with continuous s_valid and m_ready
      pulses     = 0;
      bad_period = 0;
      bad_width  = 0;
      last_pulse = 0;
      prev_mv    = 1'b0;
      m_ready    = 1'b1;
      s_valid    = 1'b1;
      for (int t = 0; t < 5000; t++) begin
         step();
         s_data = s_data + 16'd1;
         if (m_valid) begin
            if (prev_mv) bad_width++;
            if (pulses > 0 && (cyc - last_pulse) != 15) bad_period++;
            last_pulse = cyc;
            pulses++;
         end
         prev_mv = m_valid;
         if (pulses == 256) break;
      end
      s_valid = 1'b0;
      step();
      m_ready = 1'b0;
      chk("b2b_pulses",     FW'(pulses),      FW'(256));
      chk("b2b_bad_period", FW'(bad_period),  FW'(0));
      chk("b2b_bad_width",  FW'(bad_width),   FW'(0));
      chk("b2b_fc_wrap",    FW'(frame_count), FW'(8'd0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
